// File: rtl/spi_xfer_queue.sv
// Word-level TX/RX queue between register decode and the SPI master core.
// Define SPI_XFER_QUEUE_ERR_EN to build the sticky overflow/underflow ERR flag.
module spi_xfer_queue #(
  parameter int DWIDTH = 32,
  parameter int DEPTH  = 8
) (
  input  logic                   AXI_ACLK,
  input  logic                   AXI_ARESETN,
  input  logic [DWIDTH-1:0]      WDATA,
  input  logic                   WENA,
  output logic [DWIDTH-1:0]      RDATA,
  input  logic                   RENA,
  input  logic                   FLUSH,
  output logic [$clog2(DEPTH):0] TX_LEVEL,
  output logic [$clog2(DEPTH):0] RX_LEVEL,
  output logic                   TX_FULL,
  output logic                   RX_EMPTY,
  output logic                   INT,
  output logic                   ERR,
  input  logic                   ERR_CLR,
  output logic [DWIDTH-1:0]      SPI_WDATA,
  output logic                   SPI_WENA,
  input  logic                   SPI_BUSY,
  input  logic [DWIDTH-1:0]      SPI_RDATA,
  output logic                   SPI_RENA
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  typedef enum logic [2:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE, CAPTURE} state_t;

  state_t              state_q, state_d;
  logic [DWIDTH-1:0]   tx_mem_q [DEPTH];
  logic [DWIDTH-1:0]   tx_mem_d [DEPTH];
  logic [DWIDTH-1:0]   rx_mem_q [DEPTH];
  logic [DWIDTH-1:0]   rx_mem_d [DEPTH];
  logic [PW-1:0]       tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
  logic [PW-1:0]       rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
  logic [LW-1:0]       tx_level_q, tx_level_d, rx_level_q, rx_level_d;
  logic [DWIDTH-1:0]   spi_wdata_q, spi_wdata_d;
  logic                spi_wena_q, spi_wena_d, spi_rena_q, spi_rena_d;
  logic                int_q, int_d, discard_q, discard_d;
  logic                tx_full, tx_empty, rx_full, rx_empty;
  logic                tx_push, tx_pop, rx_push, rx_pop, err_rise;

  assign tx_full  = (tx_level_q == FULL_LVL);
  assign tx_empty = (tx_level_q == '0);
  assign rx_full  = (rx_level_q == FULL_LVL);
  assign rx_empty = (rx_level_q == '0);
  assign tx_push  = WENA && !tx_full;
  assign rx_pop   = RENA && !rx_empty;

  always_comb begin
    state_d     = state_q;
    spi_wdata_d = spi_wdata_q;
    discard_d   = discard_q;
    tx_pop      = 1'b0;
    rx_push     = 1'b0;
    case (state_q)
      IDLE: if (!tx_empty && !rx_full && !FLUSH) begin
        tx_pop      = 1'b1;
        spi_wdata_d = tx_mem_q[tx_rptr_q];
        state_d     = LAUNCH;
      end
      LAUNCH:    state_d = WAIT_BUSY;
      WAIT_BUSY: if (SPI_BUSY) state_d = WAIT_DONE;
      WAIT_DONE: if (!SPI_BUSY) state_d = CAPTURE;
      CAPTURE: begin
        rx_push   = !discard_q;
        discard_d = 1'b0;
        state_d   = IDLE;
      end
      default:   state_d = IDLE;
    endcase
    // A flush mid-transfer lets the core finish but drops the captured word.
    if (FLUSH && (state_q inside {LAUNCH, WAIT_BUSY, WAIT_DONE})) discard_d = 1'b1;

    tx_mem_d   = tx_mem_q;
    rx_mem_d   = rx_mem_q;
    tx_wptr_d  = tx_wptr_q;
    tx_rptr_d  = tx_rptr_q;
    rx_wptr_d  = rx_wptr_q;
    rx_rptr_d  = rx_rptr_q;
    tx_level_d = tx_level_q;
    rx_level_d = rx_level_q;
    if (FLUSH) begin
      tx_wptr_d  = '0;
      tx_rptr_d  = '0;
      rx_wptr_d  = '0;
      rx_rptr_d  = '0;
      tx_level_d = '0;
      rx_level_d = '0;
    end else begin
      if (tx_push) begin
        tx_mem_d[tx_wptr_q] = WDATA;
        tx_wptr_d = tx_wptr_q + PW'(1);
      end
      if (tx_pop) tx_rptr_d = tx_rptr_q + PW'(1);
      if (rx_push) begin
        rx_mem_d[rx_wptr_q] = SPI_RDATA;
        rx_wptr_d = rx_wptr_q + PW'(1);
      end
      if (rx_pop) rx_rptr_d = rx_rptr_q + PW'(1);
      tx_level_d = tx_level_q + LW'(tx_push) - LW'(tx_pop);
      rx_level_d = rx_level_q + LW'(rx_push) - LW'(rx_pop);
    end

    spi_wena_d = (state_d == LAUNCH);
    spi_rena_d = (state_d == CAPTURE);
    int_d      = ((state_d == CAPTURE) && !discard_d && (tx_level_d == '0)) || err_rise;
  end

  always_ff @(posedge AXI_ACLK or negedge AXI_ARESETN) begin
    if (!AXI_ARESETN) begin
      state_q     <= IDLE;
      tx_mem_q    <= '{default: '0};
      rx_mem_q    <= '{default: '0};
      tx_wptr_q   <= '0;
      tx_rptr_q   <= '0;
      rx_wptr_q   <= '0;
      rx_rptr_q   <= '0;
      tx_level_q  <= '0;
      rx_level_q  <= '0;
      spi_wdata_q <= '0;
      spi_wena_q  <= 1'b0;
      spi_rena_q  <= 1'b0;
      int_q       <= 1'b0;
      discard_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      tx_mem_q    <= tx_mem_d;
      rx_mem_q    <= rx_mem_d;
      tx_wptr_q   <= tx_wptr_d;
      tx_rptr_q   <= tx_rptr_d;
      rx_wptr_q   <= rx_wptr_d;
      rx_rptr_q   <= rx_rptr_d;
      tx_level_q  <= tx_level_d;
      rx_level_q  <= rx_level_d;
      spi_wdata_q <= spi_wdata_d;
      spi_wena_q  <= spi_wena_d;
      spi_rena_q  <= spi_rena_d;
      int_q       <= int_d;
      discard_q   <= discard_d;
    end
  end

`ifdef SPI_XFER_QUEUE_ERR_EN
  logic err_q, err_d, err_set;
  always_comb begin
    err_set = !FLUSH && ((WENA && tx_full) || (RENA && rx_empty));
    err_d   = err_q;
    if (ERR_CLR) err_d = 1'b0;
    if (err_set) err_d = 1'b1;
  end
  always_ff @(posedge AXI_ACLK or negedge AXI_ARESETN) begin
    if (!AXI_ARESETN) err_q <= 1'b0;
    else              err_q <= err_d;
  end
  assign err_rise = err_set && !err_q;
  assign ERR      = err_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = ERR_CLR;
  assign err_rise       = 1'b0;
  assign ERR            = 1'b0;
`endif

  assign RDATA     = rx_mem_q[rx_rptr_q];
  assign TX_LEVEL  = tx_level_q;
  assign RX_LEVEL  = rx_level_q;
  assign TX_FULL   = tx_full;
  assign RX_EMPTY  = rx_empty;
  assign INT       = int_q;
  assign SPI_WDATA = spi_wdata_q;
  assign SPI_WENA  = spi_wena_q;
  assign SPI_RENA  = spi_rena_q;
endmodule
